// File: rtl/imem_loader.sv
// Instruction memory with a 1-cycle fetch port and a streaming boot-load port.
// Optional build macro IMEM_PARITY_EN adds a per-word even-parity bit.
module imem_loader #(
  parameter int DATA_W = 27,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              rd_perr,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);

`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  logic [MW-1:0]     mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              we;
  logic [MW-1:0]     wword;
  logic              rd_oor;
  logic              base_oor;

  assign we       = reset_n && (state == LOAD) && ld_valid;
  assign rd_oor   = {1'b0, rd_addr} >= DEPTH_X;
  assign base_oor = {1'b0, ld_base} >= DEPTH_X;

`ifdef IMEM_PARITY_EN
  assign wword = {^ld_data, ld_data};
`else
  assign wword = ld_data;
`endif

  // Storage is never reset; nonblocking write gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[ptr] <= wword;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      rd_perr  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_oor) begin
          rd_data <= '0;
          rd_err  <= 1'b1;
          rd_perr <= 1'b0;
        end else begin
          rd_data <= mem[rd_addr][DATA_W-1:0];
          rd_err  <= 1'b0;
`ifdef IMEM_PARITY_EN
          rd_perr <= ^mem[rd_addr];
`else
          rd_perr <= 1'b0;
`endif
        end
      end else begin
        rd_err  <= 1'b0;
        rd_perr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      ld_count  <= '0;
      ld_ready  <= 1'b0;
      ld_busy   <= 1'b0;
      ld_done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ld_done <= 1'b0;
          if (ld_start) begin
            ptr       <= base_oor ? '0 : ld_base;
            remaining <= ld_len;
            ld_count  <= '0;
            if (ld_len != '0) begin
              state    <= LOAD;
              ld_ready <= 1'b1;
              ld_busy  <= 1'b1;
            end else begin
              state   <= DONE;
              ld_done <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (ld_valid) begin
            ptr       <= (ptr == LAST) ? '0 : ptr + 1'b1;
            ld_count  <= ld_count + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_W+1)'(1)) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          ld_done <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (small DEPTH, non-power-of-2).
module tb_imem_loader;
  localparam int DW = 27;
  localparam int AW = 5;
  localparam int D  = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          rd_perr;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic [AW:0]   ld_count;

  int errors = 0;
  int checks = 0;
  int dones;

  imem_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .rd_perr(rd_perr),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                       input string tag);
    rd_en = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    chk({tag, "_v"}, 32'(rd_valid), 32'd1);
    chk({tag, "_d"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0; rd_en = 1'b0; rd_addr = '0;
    ld_start = 1'b0; ld_base = '0; ld_len = '0;
    ld_valid = 1'b0; ld_data = '0;
    step(); step();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ld_busy", 32'(ld_busy), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_ld_count", 32'(ld_count), 32'd0);
    reset_n = 1'b1;
    step();

    // Load 1..4 at base 0 with valid held high
    ld_start = 1'b1; ld_base = 5'd0; ld_len = 6'd4;
    step();
    ld_start = 1'b0;
    chk("l1_ready", 32'(ld_ready), 32'd1);
    chk("l1_busy", 32'(ld_busy), 32'd1);
    ld_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ld_data = DW'(i);
      step();
      chk("l1_ready_i", 32'(ld_ready), (i < 4) ? 32'd1 : 32'd0);
      chk("l1_done_i", 32'(ld_done), (i < 4) ? 32'd0 : 32'd1);
    end
    ld_valid = 1'b0;
    chk("l1_count", 32'(ld_count), 32'd4);
    step();
    chk("l1_done_drop", 32'(ld_done), 32'd0);

    // Back-to-back fetch 0..3
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i);
      step();
      chk("f1_valid", 32'(rd_valid), 32'd1);
      chk("f1_data", 32'(rd_data), 32'(i + 1));
    end
    rd_en = 1'b0;
    step();
    chk("f1_idle_valid", 32'(rd_valid), 32'd0);
    chk("f1_hold_data", 32'(rd_data), 32'd4);

    // Wrapping load at D-2 with a stalling source
    ld_start = 1'b1; ld_base = AW'(D - 2); ld_len = 6'd3;
    step();
    ld_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data = DW'(32'h100 + i / 2);
      step();
      if (ld_done) dones++;
    end
    ld_valid = 1'b0;
    chk("l2_count", 32'(ld_count), 32'd3);
    step();
    if (ld_done) dones++;
    step();
    if (ld_done) dones++;
    chk("l2_done_once", 32'(dones), 32'd1);
    fetch(AW'(D - 2), 27'h100, "l2_m22");
    fetch(AW'(D - 1), 27'h101, "l2_m23");
    fetch(5'd0, 27'h102, "l2_m0");
    fetch(5'd1, 27'h2, "l2_m1");

    // Out-of-range fetch then last valid address
    fetch(AW'(D), 27'h0, "oor");
    chk("oor_err", 32'(rd_err), 32'd1);
    fetch(AW'(D - 1), 27'h101, "last");
    chk("last_err", 32'(rd_err), 32'd0);

    // Read-before-write collision and an ignored restart
    ld_start = 1'b1; ld_base = 5'd2; ld_len = 6'd2;
    step();
    ld_base = 5'd0; ld_len = 6'd1;
    ld_valid = 1'b1; ld_data = 27'h555;
    rd_en = 1'b1; rd_addr = 5'd2;
    step();
    ld_start = 1'b0;
    chk("rbw_old", 32'(rd_data), 32'h3);
    ld_data = 27'h556;
    step();
    ld_valid = 1'b0; rd_en = 1'b0;
    chk("rbw_new", 32'(rd_data), 32'h555);
    chk("rbw_done", 32'(ld_done), 32'd1);
    chk("rbw_count", 32'(ld_count), 32'd2);
    step();
    fetch(5'd3, 27'h556, "rbw_m3");
    fetch(5'd0, 27'h102, "rbw_m0");

    // Reset in the middle of a 5-word load
    ld_start = 1'b1; ld_base = 5'd0; ld_len = 6'd5;
    step();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 27'hA0;
    step();
    ld_data = 27'hA1;
    step();
    ld_valid = 1'b0; reset_n = 1'b0;
    step();
    chk("mr_busy", 32'(ld_busy), 32'd0);
    chk("mr_ready", 32'(ld_ready), 32'd0);
    chk("mr_done", 32'(ld_done), 32'd0);
    chk("mr_count", 32'(ld_count), 32'd0);
    reset_n = 1'b1;
    step();
    chk("mr_done2", 32'(ld_done), 32'd0);
    fetch(5'd0, 27'hA0, "mr_m0");
    fetch(5'd1, 27'hA1, "mr_m1");
    fetch(5'd2, 27'h555, "mr_m2");

    // Zero-length load
    ld_start = 1'b1; ld_base = 5'd7; ld_len = 6'd0;
    step();
    ld_start = 1'b0;
    chk("z_done", 32'(ld_done), 32'd1);
    chk("z_ready", 32'(ld_ready), 32'd0);
    chk("z_count", 32'(ld_count), 32'd0);
    step();
    chk("z_done_drop", 32'(ld_done), 32'd0);

    // Parity
    ld_start = 1'b1; ld_base = 5'd5; ld_len = 6'd1;
    step();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 27'h0ABCDE;
    step();
    ld_valid = 1'b0;
    step();
`ifdef IMEM_PARITY_EN
    fetch(5'd0, 27'hA0, "p_clean");
    chk("p_clean_perr", 32'(rd_perr), 32'd0);
    dut.mem[5] = dut.mem[5] ^ 28'h1;
    fetch(5'd5, 27'h0ABCDF, "p_bad");
    chk("p_bad_perr", 32'(rd_perr), 32'd1);
`else
    fetch(5'd5, 27'h0ABCDE, "p_off");
    chk("p_off_perr", 32'(rd_perr), 32'd0);
`endif
    fetch(AW'(D), 27'h0, "p_oor");
    chk("p_oor_perr", 32'(rd_perr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory for the multicycle computer: a DEPTH x DATA_W synchronous RAM with a pipelined one-cycle fetch port and a streaming boot-load port driven by a small load state machine. The control unit fetches through the read port. A loader (host/UART/testbench) fills program memory through the valid/ready stream, one word per cycle, with auto-incrementing addresses.

## Interface
- DATA_W, 27, instruction word width
- ADDR_W, 14, address width
- DEPTH, 16384, number of words; must be ≤ 2**ADDR_W; need not be a power of two
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- rd_en  in  1  fetch request, one per cycle
- rd_addr  in  ADDR_W  fetch address
- rd_valid  out  1  rd_data/rd_err valid
- rd_data  out  DATA_W  fetched word
- rd_err  out  1  fetch address was ≥ DEPTH
- rd_perr  out  1  parity mismatch on fetched word (see Configuration)
- ld_start  in  1  start-load pulse
- ld_base  in  ADDR_W  first load address
- ld_len  in  ADDR_W+1  number of words to load
- ld_valid  in  1  ld_data valid
- ld_data  in  DATA_W  word to store
- ld_ready  out  1  load port accepts a word
- ld_busy  out  1  load in progress
- ld_done  out  1  one-cycle completion pulse
- ld_count  out  ADDR_W+1  words written in the current or last load

## Operation
- Reset values: rd_valid 0, rd_data 0, rd_err 0, rd_perr 0, ld_ready 0, ld_busy 0, ld_done 0, ld_count 0, FSM in IDLE, load pointer 0.
- Memory contents are never cleared by reset.
- Read port:
  - rd_en sampled each cycle.
  - Next cycle: rd_valid=1 and rd_data=mem[rd_addr].
  - If rd_addr ≥ DEPTH: rd_data=0 and rd_err=1.
  - When rd_en=0 on the prior cycle: rd_valid=0, and rd_data holds its last value.
  - Reads are allowed in every FSM state.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: ld_start=1 latches ptr←ld_base, remaining←ld_len, ld_count←0. Goes to LOAD if ld_len≠0, otherwise to DONE.
  - LOAD: ld_ready=1 and ld_busy=1.
    - Each cycle with ld_valid&ld_ready: mem[ptr]←ld_data, ld_count+1, remaining−1.
    - Pointer advance: ptr←ptr+1, or ptr←0 when ptr=DEPTH−1 (wrap).
    - The accepting cycle with remaining=1 goes to DONE; ld_ready drops the following cycle.
  - DONE: ld_done=1 for exactly one cycle, ld_busy=0, then go to IDLE.
  - ld_count holds until the next ld_start.
- ld_start while in LOAD or DONE is ignored.
- ld_base ≥ DEPTH: ptr is reduced to ld_base−DEPTH... no. Instead, ld_base ≥ DEPTH is clamped to 0.
- ld_len > DEPTH: accepted. Writes wrap and overwrite earlier words.
- Read and load write to the same address in the same cycle: the read returns the old contents (read-before-write).
- Reset asserted mid-load: FSM goes to IDLE and all outputs return to reset values. Words already written are retained. No ld_done is generated.

## Timing
- Fetch latency: 1 cycle, fully pipelined, throughput 1 word per cycle.
- Load throughput: 1 word per cycle while ld_valid is held high.
- ld_start edge → ld_ready high on the next cycle.
- Last accepted word → ld_done high 1 cycle later.
- ld_len=0: ld_start → ld_done 1 cycle later, ld_ready never asserted.
- Handshake:
  - The word transfers on the clk edge where ld_valid&ld_ready.
  - ld_ready does not depend combinationally on ld_valid.
  - The source may drop ld_valid at any time (stall).

## Configuration
- IMEM_PARITY_EN defined:
  - Storage is DATA_W+1 bits per word; an even-parity bit is computed on each load write.
  - On each fetch, rd_perr=1 alongside rd_valid when the stored parity mismatches. rd_data is still returned.
  - rd_perr=0 for out-of-range reads.
- IMEM_PARITY_EN undefined:
  - Storage is DATA_W bits; rd_perr is tied to 0.
  - All other behaviour is identical.
- The storage array is named mem in both builds, so benches can deposit errors hierarchically.

## Test plan
- Reset, then load ld_base=0, ld_len=4, words 27'h0000001..27'h0000004 with ld_valid held high → ld_ready for 4 cycles, ld_done 1 cycle after the 4th, ld_count=4. Fetch addresses 0..3 back-to-back → rd_data 1..4 with 1-cycle latency.
- Load ld_base=DEPTH−2, ld_len=3, ld_valid toggled 1,0,1,0,1 → words land at DEPTH−2, DEPTH−1, 0; ld_count=3; ld_done exactly once.
- Fetch rd_addr=DEPTH (with DEPTH<2**ADDR_W) → rd_valid=1, rd_err=1, rd_data=0. Then fetch rd_addr=DEPTH−1 → rd_err=0.
- During LOAD, fetch the address being written in that cycle → old value returned; the following fetch of that address returns the new value. A second ld_start during LOAD is ignored.
- Assert reset_n=0 after 2 of 5 load words → ld_busy=0, ld_ready=0, no ld_done; the 2 written words read back correctly and the third address is unchanged. A ld_len=0 start → ld_done 1 cycle later.
- With IMEM_PARITY_EN: flip bit 0 of mem[5] by deposit, fetch address 5 → rd_perr=1 and rd_data equals the corrupted word. Without IMEM_PARITY_EN: rd_perr stays 0.
